imem_fetch: RTL and testbench

Parametrised, clocked instruction memory for the single-cycle/multi-cycle CPU datapath: byte-addressed storage returning a 32-bit instruction word per fetch. Replaces the combinational ROM with a valid/ready request/response port, selectable byte order, alignment and bounds checking, and an optional byte-wide program loader. Sits between the PC/fetch stage and the instruction register.

---
 rtl/imem_fetch_if.sv | 28 ++
 rtl/imem_fetch.sv | 108 ++++++++++
 tb/tb_imem_fetch.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Fetch/response and loader handshake bundle between the fetch stage (master)
// and the instruction memory (slave).
interface imem_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_err;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic [ADDR_W-1:0] ld_count;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_valid, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, ld_ready, ld_count
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_valid, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, ld_ready, ld_count
    );
endinterface

// File: rtl/imem_fetch.sv
// Byte-addressed instruction memory with a registered valid/ready fetch port.
// Define IMEM_LOAD_EN to build the byte-wide program loader; otherwise read-only.
module imem_fetch #(
    parameter int    ADDR_W     = 32,
    parameter int    DEPTH      = 512,
    parameter bit    BIG_ENDIAN = 1'b1,
    parameter string INIT_FILE  = ""
) (
    input  logic         clk,
    input  logic         rst,
    imem_fetch_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 4);

    typedef enum logic {IDLE, RSP} state_t;

    state_t      state_q, state_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_err_q, rsp_err_d;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  rd_byte [4];
    logic [31:0] rd_word;
    logic        misaligned;
    logic        out_of_range;
    logic        req_fire;

    // OR-ing the lane number equals adding it whenever the address is aligned;
    // misaligned fetches return zero, so their lanes never matter.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd
            assign rd_byte[gi] = mem[bus.req_addr[IDX_W-1:0] | IDX_W'(gi)];
        end
    endgenerate

    assign rd_word = BIG_ENDIAN ? {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]}
                                : {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

    assign misaligned   = |bus.req_addr[1:0];
    assign out_of_range = bus.req_addr > LAST_WORD;
    assign req_fire     = bus.req_valid & bus.req_ready;

`ifdef IMEM_LOAD_EN
    logic [ADDR_W-1:0] ld_count_q, ld_count_d;
    logic              ld_fire;

    assign bus.ld_ready  = (state_q == IDLE);
    assign bus.req_ready = !bus.ld_valid & ((state_q == IDLE) | bus.rsp_ready);
    assign bus.ld_count  = ld_count_q;
    assign ld_fire       = bus.ld_valid & bus.ld_ready;

    always_comb begin
        ld_count_d = ld_count_q;
        if (ld_fire && !(&ld_count_q)) ld_count_d = ld_count_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ld_count_q <= '0;
        else     ld_count_q <= ld_count_d;
    end

    // Out-of-range loader bytes are accepted and counted but dropped here.
    always_ff @(posedge clk) begin
        if (ld_fire && (bus.ld_addr < ADDR_W'(DEPTH)))
            mem[bus.ld_addr[IDX_W-1:0]] <= bus.ld_data;
    end
`else
    logic unused_ld;

    assign bus.ld_ready  = 1'b0;
    assign bus.ld_count  = '0;
    assign bus.req_ready = (state_q == IDLE) | bus.rsp_ready;
    assign unused_ld     = ^{bus.ld_valid, bus.ld_addr, bus.ld_data};
`endif

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = RSP;
            RSP:     if (bus.rsp_ready) state_d = req_fire ? RSP : IDLE;
            default: state_d = IDLE;
        endcase
        if (req_fire) begin
            rsp_err_d  = {out_of_range, misaligned};
            rsp_data_d = (misaligned | out_of_range) ? 32'h0 : rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = (state_q == RSP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: big- and little-endian instances fed identical stimulus.
module tb_imem_fetch;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imem_fetch_if #(.ADDR_W(32)) be_if ();
    imem_fetch_if #(.ADDR_W(32)) le_if ();

    imem_fetch #(.ADDR_W(32), .DEPTH(512), .BIG_ENDIAN(1'b1), .INIT_FILE("")) dut_be (
        .clk(clk), .rst(rst), .bus(be_if.slave)
    );
    imem_fetch #(.ADDR_W(32), .DEPTH(512), .BIG_ENDIAN(1'b0), .INIT_FILE("")) dut_le (
        .clk(clk), .rst(rst), .bus(le_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [31:0] a, input logic rdy);
        be_if.req_valid = v;  be_if.req_addr = a;  be_if.rsp_ready = rdy;
        le_if.req_valid = v;  le_if.req_addr = a;  le_if.rsp_ready = rdy;
    endtask

    task automatic drive_ld(input logic v, input logic [31:0] a, input logic [7:0] d);
        be_if.ld_valid = v;  be_if.ld_addr = a;  be_if.ld_data = d;
        le_if.ld_valid = v;  le_if.ld_addr = a;  le_if.ld_data = d;
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [7:0] d);
        drive_ld(1'b1, a, d);
        tick();
        drive_ld(1'b0, a, d);
        $display("load  addr=%h data=%h count=%0d", a, d, be_if.ld_count);
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
`ifdef IMEM_LOAD_EN
        ld_write(a, d);
`else
        dut_be.mem[a[8:0]] = d;
        dut_le.mem[a[8:0]] = d;
`endif
    endtask

    task automatic fetch_chk(input logic [31:0] a, input logic [31:0] exp_be,
                             input logic [31:0] exp_le, input logic [1:0] exp_err);
        drive_req(1'b1, a, 1'b1);
        tick();
        drive_req(1'b0, a, 1'b1);
        chk("fetch_valid", {31'b0, be_if.rsp_valid}, 32'd1);
        chk("fetch_data_be", be_if.rsp_data, exp_be);
        chk("fetch_data_le", le_if.rsp_data, exp_le);
        chk("fetch_err", {30'b0, be_if.rsp_err}, {30'b0, exp_err});
        $display("fetch addr=%h be=%h le=%h err=%b", a, be_if.rsp_data, le_if.rsp_data, be_if.rsp_err);
        tick();
        chk("fetch_consumed", {31'b0, be_if.rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] ld_bytes [4];
        ld_bytes[0] = 8'hAA; ld_bytes[1] = 8'hBB; ld_bytes[2] = 8'hCC; ld_bytes[3] = 8'hDD;

        rst = 1'b1;
        drive_req(1'b0, 32'h0, 1'b0);
        drive_ld(1'b0, 32'h0, 8'h00);
        tick();
        tick();
        chk("rst_rsp_valid", {31'b0, be_if.rsp_valid}, 32'd0);
        chk("rst_rsp_data", be_if.rsp_data, 32'h0);
        chk("rst_rsp_err", {30'b0, be_if.rsp_err}, 32'h0);
        chk("rst_ld_count", be_if.ld_count, 32'h0);
        chk("rst_req_ready", {31'b0, be_if.req_ready}, 32'd1);
`ifdef IMEM_LOAD_EN
        chk("rst_ld_ready", {31'b0, be_if.ld_ready}, 32'd1);
`else
        chk("rst_ld_ready", {31'b0, be_if.ld_ready}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        preload(32'h000, 8'h20); preload(32'h001, 8'h08); preload(32'h002, 8'h00); preload(32'h003, 8'h05);
        preload(32'h004, 8'h11); preload(32'h005, 8'h22); preload(32'h006, 8'h33); preload(32'h007, 8'h44);
        preload(32'h008, 8'h55); preload(32'h009, 8'h66); preload(32'h00A, 8'h77); preload(32'h00B, 8'h88);
        preload(32'h1FC, 8'hDE); preload(32'h1FD, 8'hAD); preload(32'h1FE, 8'hBE); preload(32'h1FF, 8'hEF);
`ifdef IMEM_LOAD_EN
        chk("preload_count", be_if.ld_count, 32'd16);
`endif

        fetch_chk(32'h0000_0000, 32'h2008_0005, 32'h0500_0820, 2'b00);
        fetch_chk(32'h0000_0004, 32'h1122_3344, 32'h4433_2211, 2'b00);
        fetch_chk(32'h0000_0002, 32'h0,         32'h0,         2'b01);
        fetch_chk(32'h0000_01FE, 32'h0,         32'h0,         2'b11);
        fetch_chk(32'h0000_01FC, 32'hDEAD_BEEF, 32'hEFBE_ADDE, 2'b00);
        fetch_chk(32'h0000_0200, 32'h0,         32'h0,         2'b10);
        fetch_chk(32'hFFFF_FFFC, 32'h0,         32'h0,         2'b10);

        // back-to-back fetches with the consumer stalled on the first
        drive_req(1'b1, 32'h0, 1'b0);
        tick();
        drive_req(1'b1, 32'h4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {31'b0, be_if.rsp_valid}, 32'd1);
            chk("stall_data", be_if.rsp_data, 32'h2008_0005);
            chk("stall_req_ready", {31'b0, be_if.req_ready}, 32'd0);
            tick();
        end
        chk("stall_data_end", be_if.rsp_data, 32'h2008_0005);
        drive_req(1'b1, 32'h4, 1'b1);
        #1;
        chk("b2b_req_ready", {31'b0, be_if.req_ready}, 32'd1);
        tick();
        chk("b2b_word4", be_if.rsp_data, 32'h1122_3344);
        chk("b2b_word4_le", le_if.rsp_data, 32'h4433_2211);
        $display("fetch addr=%h be=%h le=%h err=%b", 32'h4, be_if.rsp_data, le_if.rsp_data, be_if.rsp_err);
        drive_req(1'b1, 32'h8, 1'b1);
        tick();
        chk("b2b_word8", be_if.rsp_data, 32'h5566_7788);
        chk("b2b_word8_valid", {31'b0, be_if.rsp_valid}, 32'd1);
        $display("fetch addr=%h be=%h le=%h err=%b", 32'h8, be_if.rsp_data, le_if.rsp_data, be_if.rsp_err);
        drive_req(1'b0, 32'h8, 1'b1);
        tick();
        chk("b2b_idle", {31'b0, be_if.rsp_valid}, 32'd0);

`ifdef IMEM_LOAD_EN
        // loader has priority over a pending fetch
        drive_req(1'b1, 32'h10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_ld(1'b1, 32'h10 + 32'(i), ld_bytes[i]);
            #1;
            chk("ld_req_ready", {31'b0, be_if.req_ready}, 32'd0);
            chk("ld_ld_ready", {31'b0, be_if.ld_ready}, 32'd1);
            tick();
            $display("load  addr=%h data=%h count=%0d", 32'h10 + 32'(i), ld_bytes[i], be_if.ld_count);
        end
        drive_ld(1'b0, 32'h0, 8'h00);
        chk("ld_count_20", be_if.ld_count, 32'd20);
        #1;
        chk("ld_req_ready_after", {31'b0, be_if.req_ready}, 32'd1);
        tick();
        drive_req(1'b0, 32'h10, 1'b1);
        chk("ld_fetch_be", be_if.rsp_data, 32'hAABB_CCDD);
        chk("ld_fetch_le", le_if.rsp_data, 32'hDDCC_BBAA);
        $display("fetch addr=%h be=%h le=%h err=%b", 32'h10, be_if.rsp_data, le_if.rsp_data, be_if.rsp_err);
        tick();
        ld_write(32'h200, 8'h99);
        chk("ld_count_oob", be_if.ld_count, 32'd21);
        fetch_chk(32'h0000_0000, 32'h2008_0005, 32'h0500_0820, 2'b00);
`else
        // loader inputs are ignored when the loader is not built
        drive_ld(1'b1, 32'h0, 8'hFF);
        drive_req(1'b1, 32'h0, 1'b1);
        #1;
        chk("noload_req_ready", {31'b0, be_if.req_ready}, 32'd1);
        chk("noload_ld_ready", {31'b0, be_if.ld_ready}, 32'd0);
        tick();
        drive_req(1'b0, 32'h0, 1'b1);
        drive_ld(1'b0, 32'h0, 8'h00);
        chk("noload_fetch", be_if.rsp_data, 32'h2008_0005);
        chk("noload_ld_count", be_if.ld_count, 32'h0);
        tick();
`endif

        // reset while a response is pending
        drive_req(1'b1, 32'h4, 1'b0);
        tick();
        drive_req(1'b0, 32'h4, 1'b0);
        chk("rstmid_pending", {31'b0, be_if.rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", {31'b0, be_if.rsp_valid}, 32'd0);
        chk("rstmid_data", be_if.rsp_data, 32'h0);
        chk("rstmid_ld_count", be_if.ld_count, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        fetch_chk(32'h0000_0000, 32'h2008_0005, 32'h0500_0820, 2'b00);
`ifdef IMEM_LOAD_EN
        fetch_chk(32'h0000_0010, 32'hAABB_CCDD, 32'hDDCC_BBAA, 2'b00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
